// File: rtl/qtx_pkg.sv
// ----------------------------------------------------------------------------
// qtx_pkg
// Shared definitions for the q-line stimulus transmitter.
//   - qtx_state_e : frame FSM state encoding
//   - QTX_LEN_W   : default width of the hold length and z counter
//   - QTX_Z_SAT   : largest z count the detector can return
//   - min_len()   : expected detector count for a given hold length
// ----------------------------------------------------------------------------
package qtx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_PRE  = 3'b001,
        ST_MARK = 3'b010,
        ST_HOLD = 3'b011,
        ST_DONE = 3'b100
    } qtx_state_e;

    localparam int QTX_LEN_W = 5;
    localparam int QTX_Z_SAT = 19;

    // The detector caps its response, so the count we expect back is the
    // smaller of the programmed hold length and that cap.
    function automatic int unsigned min_len(input int unsigned len_val,
                                            input int unsigned sat);
        return (len_val < sat) ? len_val : sat;
    endfunction

endpackage

// File: rtl/qtx_zcount.sv
// ----------------------------------------------------------------------------
// qtx_zcount
// Saturating up-counter for detector z responses.
// Ports:
//   clk       : rising-edge clock
//   init      : asynchronous active-low reset (count -> 0)
//   clr       : synchronous clear (wins over en)
//   en        : count window enable
//   inc       : increment request, honoured only while en=1
//   count     : current count, sticks at all-ones
//   count_nxt : value count would take if inc were accepted this cycle
// ----------------------------------------------------------------------------
module qtx_zcount #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         init,
    input  logic         clr,
    input  logic         en,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic [W-1:0] count_nxt
);

    always_comb begin
        count_nxt = count;
        if (inc && (count != {W{1'b1}})) begin
            count_nxt = count + W'(1);
        end
    end

    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/q_stream_tx.sv
// ----------------------------------------------------------------------------
// q_stream_tx
// Serial stimulus transmitter driving the q-line sequence detector.
// A frame is: preamble (MSB first) -> MARK_CYC cycles of q=1 -> len cycles of
// q=0 (HOLD) -> one DONE cycle. Detector z responses are counted over HOLD
// plus the DONE cycle (the detector answers one cycle late).
//
// Optional feature macro: QTX_ABORT_EN adds an 'abort' input that drops any
// running frame back to IDLE without a done pulse.
//
// Ports:
//   clk     : rising-edge clock
//   init    : asynchronous active-low reset
//   start   : frame request, only looked at in IDLE
//   len     : hold length, latched when start is accepted
//   abort   : (QTX_ABORT_EN only) cancel the running frame
//   z_in    : detector z output
//   busy    : frame in progress
//   done    : one-cycle end-of-frame pulse
//   q       : registered serial line to the detector
//   z_count : z-high cycles seen in the count window
//   match   : while done=1, z count equals min(len, Z_SAT)
//
// state | meaning
// IDLE  | q=0, waiting for start
// PRE   | shifting preamble bits onto q
// MARK  | q=1 marker window
// HOLD  | q=0 for the latched length, counting z
// DONE  | end-of-frame pulse, last z sample
// ----------------------------------------------------------------------------
module q_stream_tx
    import qtx_pkg::*;
#(
    parameter int               PRE_W    = 4,
    parameter logic [PRE_W-1:0] PREAMBLE = 4'b0011,
    parameter int               MARK_CYC = 2,
    parameter int               LEN_W    = QTX_LEN_W,
    parameter int               Z_SAT    = QTX_Z_SAT
) (
    input  logic             clk,
    input  logic             init,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
`ifdef QTX_ABORT_EN
    input  logic             abort,
`endif
    input  logic             z_in,
    output logic             busy,
    output logic             done,
    output logic             q,
    output logic [LEN_W-1:0] z_count,
    output logic             match
);

    // Phase counter has to hold the largest of: len-1, PRE_W-1, MARK_CYC-1.
    localparam int PRE_CW = $clog2(PRE_W) + 1;
    localparam int MIN_CW = (PRE_CW > 3) ? PRE_CW : 3;
    localparam int CNT_W  = (LEN_W > MIN_CW) ? LEN_W : MIN_CW;

    qtx_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [PRE_W-1:0] sh;
    logic [LEN_W-1:0] len_l;
    logic [LEN_W-1:0] z_nxt;
    logic [LEN_W-1:0] z_expect;
    logic             abort_hit;
    logic             z_clr;
    logic             z_en;

`ifdef QTX_ABORT_EN
    assign abort_hit = abort && (state != ST_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            state <= ST_IDLE;
            q     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            len_l <= '0;
            cnt   <= '0;
            sh    <= '0;
        end else if (abort_hit) begin
            state <= ST_IDLE;
            q     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    q    <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        // First preamble bit goes out on the accepting edge;
                        // the rest are shifted from sh one per cycle.
                        len_l <= len;
                        state <= ST_PRE;
                        busy  <= 1'b1;
                        q     <= PREAMBLE[PRE_W-1];
                        sh    <= PREAMBLE << 1;
                        cnt   <= CNT_W'(PRE_W - 1);
                    end
                end
                ST_PRE: begin
                    if (cnt == '0) begin
                        state <= ST_MARK;
                        q     <= 1'b1;
                        cnt   <= CNT_W'(MARK_CYC - 1);
                    end else begin
                        q   <= sh[PRE_W-1];
                        sh  <= sh << 1;
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_MARK: begin
                    if (cnt == '0) begin
                        q <= 1'b0;
                        if (len_l != '0) begin
                            state <= ST_HOLD;
                            cnt   <= CNT_W'(len_l) - CNT_W'(1);
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    q <= 1'b0;
                    if (cnt == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    q     <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    q     <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign z_clr = (state == ST_IDLE) && start;
    assign z_en  = ((state == ST_HOLD) || (state == ST_DONE)) && !abort_hit;

    qtx_zcount #(
        .W (LEN_W)
    ) u_zcount (
        .clk       (clk),
        .init      (init),
        .clr       (z_clr),
        .en        (z_en),
        .inc       (z_in),
        .count     (z_count),
        .count_nxt (z_nxt)
    );

    // The last z sample lands on the edge that leaves DONE, so match looks
    // ahead at the count including the current z_in rather than waiting.
    assign z_expect = LEN_W'(min_len(32'(len_l), 32'(Z_SAT)));
    assign match    = done && (z_nxt == z_expect);

endmodule

// File: tb/tb_q_stream_tx.sv
module tb_q_stream_tx;

    localparam int PRE_W    = 4;
    localparam int MARK_CYC = 2;
    localparam int H        = PRE_W + MARK_CYC;
    localparam int Z_SAT    = 19;
    localparam int ZMAX     = 31;

    localparam int M_DET    = 0;
    localparam int M_ALLHI  = 1;
    localparam int M_RAND   = 2;
    localparam int M_DONEHI = 3;

    typedef struct {
        int          zc;
        bit          m;
        int          qlen;
        logic [63:0] qv;
    } exp_t;

    logic       clk = 1'b0;
    logic       init;
    logic       start;
    logic [4:0] len;
    logic       z_in;
    logic       busy;
    logic       done;
    logic       q;
    logic [4:0] z_count;
    logic       match;
`ifdef QTX_ABORT_EN
    logic       abort;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    logic qcap[$];
    logic [3:0] pre_pat = 4'b0011;

    always #5 clk = ~clk;

    q_stream_tx dut (
        .clk     (clk),
        .init    (init),
        .start   (start),
        .len     (len),
`ifdef QTX_ABORT_EN
        .abort   (abort),
`endif
        .z_in    (z_in),
        .busy    (busy),
        .done    (done),
        .q       (q),
        .z_count (z_count),
        .match   (match)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Monitor: collects q while busy, pops the scoreboard on each done pulse.
    initial begin : monitor
        exp_t        cur;
        bit          pend;
        logic [63:0] got;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk("z_count", 64'(z_count), 64'(cur.zc));
                chk("busy_after_done", 64'(busy), 64'd0);
                pend = 1'b0;
            end
            if (busy) qcap.push_back(q);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    cur = sb.pop_front();
                    got = '0;
                    foreach (qcap[i]) if (i < 64) got[i] = qcap[i];
                    chk("match", 64'(match), 64'(cur.m));
                    chk("busy_len", 64'(qcap.size()), 64'(cur.qlen));
                    chk("q_seq", got, cur.qv);
                    pend = 1'b1;
                end
                qcap.delete();
            end else if (!busy) begin
                qcap.delete();
            end
        end
    end

    // Issue one frame from the input phase (just after a rising edge).
    // Random start pulses and len changes during the frame must be ignored.
    task automatic run_frame(input int l, input int mode);
        logic zv[64];
        exp_t e;
        int   c;
        for (int k = 0; k < 64; k++) zv[k] = 1'($urandom % 2);
        for (int k = H; k <= H + l; k++) begin
            case (mode)
                M_DET, M_DONEHI: zv[k] = (k >= H + 1) && (k <= H + imin(l, Z_SAT));
                M_ALLHI:         zv[k] = 1'b1;
                default:         ;
            endcase
        end
        if (mode == M_DONEHI) zv[H + l] = 1'b1;
        c = 0;
        for (int k = H; k <= H + l; k++) c += int'(zv[k]);
        e.zc   = (c > ZMAX) ? ZMAX : c;
        e.m    = (e.zc == imin(l, Z_SAT));
        e.qlen = H + l + 1;
        e.qv   = '0;
        for (int i = 0; i < PRE_W; i++) e.qv[i] = pre_pat[PRE_W-1-i];
        for (int i = PRE_W; i < H; i++) e.qv[i] = 1'b1;
        sb.push_back(e);

        start = 1'b1;
        len   = 5'(l);
        z_in  = 1'($urandom % 2);
        @(posedge clk);
        for (int k = 0; k <= H + l; k++) begin
            #1;
            start = 1'($urandom % 2);
            len   = 5'($urandom);
            z_in  = zv[k];
            @(posedge clk);
        end
        #1;
        start = 1'b0;
        z_in  = 1'($urandom % 2);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        init  = 1'b0;
        start = 1'b0;
        len   = '0;
        z_in  = 1'b0;
`ifdef QTX_ABORT_EN
        abort = 1'b0;
`endif
        #3;
        chk("rst_q", 64'(q), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_z_count", 64'(z_count), 64'd0);
        chk("rst_match", 64'(match), 64'd0);
        repeat (3) @(posedge clk);
        #1 init = 1'b1;
        @(posedge clk);
        #1;

        run_frame(5,  M_DET);
        run_frame(25, M_DET);
        run_frame(25, M_ALLHI);
        run_frame(0,  M_DET);
        run_frame(0,  M_DONEHI);
        run_frame(31, M_ALLHI);
        run_frame(19, M_DET);
        run_frame(20, M_DET);
        run_frame(1,  M_DONEHI);

        // Reset in the middle of HOLD: outputs clear without a clock edge.
        start = 1'b1;
        len   = 5'd8;
        @(posedge clk);
        for (int k = 0; k < H + 2; k++) begin
            #1;
            start = 1'($urandom % 2);
            z_in  = 1'b1;
            @(posedge clk);
        end
        #3 init = 1'b0;
        #1;
        chk("midrst_q", 64'(q), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_z_count", 64'(z_count), 64'd0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 init = 1'b1;
        run_frame(7, M_DET);

`ifdef QTX_ABORT_EN
        start = 1'b1;
        len   = 5'd5;
        @(posedge clk);
        for (int k = 0; k < PRE_W; k++) begin
            #1;
            start = 1'b0;
            z_in  = 1'($urandom % 2);
            @(posedge clk);
        end
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_q", 64'(q), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_z_count", 64'(z_count), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        run_frame(3, M_DET);
`endif

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            run_frame(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
        end

        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/q_stream_tx.md
Name: q_stream_tx

Overview:
- Serial stimulus transmitter for the q-line sequence detector: the driving end of the q/z interface.
- On a start request it emits a preamble bit pattern, then a marker '1' window, then a q-low hold of programmable length.
- It counts the detector's z responses during the hold and reports whether the count matches the length.
- Sits beside the detector in the sequence subsystem; drives q, consumes z.

Parameters:
- PRE_W, 4, preamble length in bits.
- PREAMBLE, 4'b0011, preamble pattern, sent MSB first.
- MARK_CYC, 2, cycles q is held at 1 after the preamble (1..7).
- LEN_W, 5, width of hold length and z counter.
- Z_SAT, 19, maximum z count the detector can return; expected count = min(len, Z_SAT).

Ports:
- clk  input  1  rising-edge clock.
- init  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- len  input  LEN_W  hold length in cycles; latched when start is accepted.
- busy  output  1  high from the cycle after start is accepted until DONE exits.
- done  output  1  one-cycle pulse in the DONE state.
- q  output  1  registered serial line to the detector.
- z_in  input  1  detector z output, sampled on clk.
- z_count  output  LEN_W  z-high cycles counted during HOLD; holds its value until the next accepted start.
- match  output  1  valid while done=1: z_count == min(len_latched, Z_SAT).

Behaviour:
- Reset (init=0, asynchronous): state=IDLE, q=0, busy=0, done=0, z_count=0, match=0, latched len=0, all internal counters=0.
- States: IDLE, PRE, MARK, HOLD, DONE. Encoded 3 bits: IDLE=000, PRE=001, MARK=010, HOLD=011, DONE=100. Unused codes go to IDLE with q=0.
- IDLE, q=0: on start=1, latch len, clear z_count, go to PRE.
- PRE: q = PREAMBLE[PRE_W-1-i] for i=0..PRE_W-1, one bit per cycle; the first bit appears on q the cycle after start is sampled. After PRE_W cycles go to MARK.
- MARK: q=1 for MARK_CYC cycles. Then go to HOLD if len_latched>0, else DONE.
- HOLD: q=0 for exactly len_latched cycles. z_count increments on each clk edge where z_in=1 while in HOLD, plus one extra sample on the first DONE edge to absorb the detector's one-cycle output lag. z_count saturates at 2^LEN_W-1 with no wrap. Then go to DONE.
- DONE: q=0, done=1 for one cycle, match computed from the final z_count. Then go to IDLE. busy drops in the same cycle.
- start while busy is ignored; no queueing.
- len=0: PRE, MARK, DONE only; expected count 0; any z_in high on the DONE sample clears match.
- Reset mid-frame: immediate return to IDLE with q=0. No done pulse.
- Total frame length = PRE_W + MARK_CYC + len + 1 cycles of busy.

Optional Feature:
- QTX_ABORT_EN
- Defined: adds input abort (1 bit). abort=1 in any non-IDLE state forces IDLE next cycle with q=0, busy=0, done=0, match=0; z_count holds its value. abort in IDLE is ignored.
- Undefined: no abort port; a frame always runs to DONE.

Decomposition:
- Package qtx_pkg:
  - state encodings IDLE/PRE/MARK/HOLD/DONE;
  - LEN_W default;
  - Z_SAT default;
  - function min_len(len, sat) for the expected-count calculation.
- One sub-module, qtx_zcount: saturating up-counter with synchronous clear and enable, and asynchronous active-low init. Instantiated for z_count.
- The preamble shifter and phase counter stay in the top module.

Test Plan:
- Reset: init=0 during activity -> q=0, busy=0, done=0, z_count=0 immediately, without waiting for a clock edge.
- Basic frame: start, len=5, z_in tied to a model asserting z for 5 hold cycles -> q=0,0,1,1 then 1,1 then 0×5; done at cycle 12 after start; z_count=5, match=1.
- Saturated expectation: len=25 with the detector model capping z at 19 cycles -> z_count=19, match=1. Same run with z forced high for all 25 cycles plus the extra sample -> z_count=26, match=0.
- len=0: start -> 6 busy cycles after PRE and MARK, done=1, z_count=0, match=1. z_in=1 on the DONE sample -> match=0.
- Busy lockout and mid-frame reset: start pulses during PRE/HOLD are ignored. init low during HOLD -> IDLE, no done pulse; the next start runs a clean frame.
- QTX_ABORT_EN: abort in MARK -> q=0 and busy=0 next cycle, done never asserts, z_count holds its value.
